// File: rtl/param_cache.sv
// param_cache: direct-mapped write-through, no-write-allocate cache with burst line fill over req/ack.
// Define CACHE_STATS_EN to enable the saturating hit/miss counters.
module param_cache #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int LINES   = 16,
    parameter int WORDS   = 4,
    parameter int STATS_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_read,
    input  logic                     cpu_write,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_ready,
    output logic                     hit,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic [2:0]               state,
    output logic [$clog2(WORDS)-1:0] count,
    output logic [STATS_W-1:0]       hit_count,
    output logic [STATS_W-1:0]       miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE_MEM, RESPOND} state_t;

    state_t st, st_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q, hit_q;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES][WORDS];
    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [OFF_W-1:0]  a_off;
    logic              lookup_hit, ack;

    assign {a_tag, a_idx, a_off} = addr_q;
    assign lookup_hit = valid[a_idx] && tags[a_idx] == a_tag;
    assign ack = mem_req && mem_ack;
    assign state = st;

    always_ff @(posedge clock) begin
        if (reset) st <= IDLE;
        else st <= st_n;
    end

    always_comb begin
        st_n = st;
        case (st)
            IDLE:      st_n = (cpu_read || cpu_write) ? LOOKUP : IDLE;
            LOOKUP:    st_n = wr_q ? WRITE_MEM : (lookup_hit ? RESPOND : FILL);
            FILL:      st_n = (ack && &count) ? RESPOND : FILL;
            WRITE_MEM: st_n = ack ? RESPOND : WRITE_MEM;
            default:   st_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            hit_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            cpu_rdata <= '0;
            count     <= '0;
        end else begin
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            cpu_rdata <= '0;
            case (st)
                IDLE: if (cpu_read || cpu_write) begin
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                    wr_q    <= !cpu_read;
                end
                LOOKUP: begin
                    hit_q <= lookup_hit;
                    if (wr_q) begin
                        if (lookup_hit) data[a_idx][a_off] <= wdata_q;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= wdata_q;
                    end else if (lookup_hit) begin
                        cpu_ready <= 1'b1;
                        hit       <= 1'b1;
                        cpu_rdata <= data[a_idx][a_off];
                    end else begin
                        // the line stays invalid until its final word lands, so an abort leaves no stale line
                        valid[a_idx] <= 1'b0;
                        count        <= '0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= {a_tag, a_idx, {OFF_W{1'b0}}};
                    end
                end
                FILL: if (ack) begin
                    data[a_idx][count] <= mem_rdata;
                    if (&count) begin
                        valid[a_idx] <= 1'b1;
                        tags[a_idx]  <= a_tag;
                        mem_req      <= 1'b0;
                        count        <= '0;
                        cpu_ready    <= 1'b1;
                        hit          <= hit_q;
                        cpu_rdata    <= (a_off == count) ? mem_rdata : data[a_idx][a_off];
                    end else begin
                        count    <= count + 1'b1;
                        mem_addr <= {a_tag, a_idx, count + 1'b1};
                    end
                end
                WRITE_MEM: if (ack) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    cpu_ready <= 1'b1;
                    hit       <= hit_q;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (st == RESPOND) begin
            if (hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (!hit && !(&miss_count)) miss_count <= miss_count + 1'b1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule
